// File: rtl/print_mech_pkg.sv
// Shared types and helpers for the print mechanism / host-link blocks.
package print_mech_pkg;

    localparam int LINE_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } stream_state_t;

    // Number of output words needed to carry one full print line.
    function automatic int words_per_line(input int head_w, input int word_w);
        return head_w / word_w;
    endfunction

endpackage

// File: rtl/line_slot_queue.sv
// Single-clock ring of LINE_SLOTS entries, each {sequence number, print line}.
// Occupancy is registered so full/empty never depend on same-cycle push/pop.
module line_slot_queue
    import print_mech_pkg::*;
#(
    parameter int HEAD_WIDTH = 384,
    parameter int LINE_SLOTS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [LINE_COUNT_WIDTH-1:0] push_seq,
    input  logic [HEAD_WIDTH-1:0]       push_line,
    input  logic                        pop,
    output logic [LINE_COUNT_WIDTH-1:0] head_seq,
    output logic [HEAD_WIDTH-1:0]       head_line,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
    localparam int CNT_W = $clog2(LINE_SLOTS + 1);

    logic [LINE_COUNT_WIDTH-1:0] seq_mem  [LINE_SLOTS];
    logic [HEAD_WIDTH-1:0]       line_mem [LINE_SLOTS];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at LINE_SLOTS explicitly so the ring is correct even
    // when the pointer register is wider than the slot index range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LINE_SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(LINE_SLOTS));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_seq  = seq_mem[rd_ptr];
    assign head_line = line_mem[rd_ptr];

    // Slot storage: contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            seq_mem[wr_ptr]  <= push_seq;
            line_mem[wr_ptr] <= push_line;
        end
    end

    // Ring pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/print_line_streamer.sv
// Captures completed print lines into a small queue and streams each one to
// the host link as a sequence-number header word followed by its data words.
module print_line_streamer
    import print_mech_pkg::*;
#(
    parameter int HEAD_WIDTH = 384,
    parameter int WORD_WIDTH = 8,
    parameter int LINE_SLOTS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        line_advance_tick,
    input  logic [HEAD_WIDTH-1:0]       print_line,
    input  logic                        capture_enable,
    input  logic                        clear_overflow,
    output logic [WORD_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [LINE_COUNT_WIDTH-1:0] line_count,
    output logic                        overflow,
    output logic                        busy
);

    localparam int WPL   = words_per_line(HEAD_WIDTH, WORD_WIDTH);
    localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;

    if ((HEAD_WIDTH % WORD_WIDTH) != 0) begin : g_bad_word_width
        $error("print_line_streamer: HEAD_WIDTH must be a multiple of WORD_WIDTH");
    end
    if ((LINE_SLOTS < 1) || ((LINE_SLOTS & (LINE_SLOTS - 1)) != 0)) begin : g_bad_slots
        $error("print_line_streamer: LINE_SLOTS must be a power of two >= 1");
    end

    stream_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic                        push, drop, pop;
    logic                        q_full, q_empty;
    logic [LINE_COUNT_WIDTH-1:0] head_seq;
    logic [HEAD_WIDTH-1:0]       head_line;
    logic [WPL-1:0][WORD_WIDTH-1:0] head_words;
    logic [IDX_W-1:0]            word_sel;
    logic                        last_word;
    logic                        unused_seq_bits;

    assign push = line_advance_tick & capture_enable & ~q_full;
    assign drop = line_advance_tick & capture_enable & q_full;

    line_slot_queue #(
        .HEAD_WIDTH (HEAD_WIDTH),
        .LINE_SLOTS (LINE_SLOTS)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_seq  (line_count),
        .push_line (print_line),
        .pop       (pop),
        .head_seq  (head_seq),
        .head_line (head_line),
        .full      (q_full),
        .empty     (q_empty)
    );

    // View the line as words; the highest word holds the first dots shifted in.
    assign head_words = head_line;
    assign word_sel   = IDX_W'(WPL - 1) - idx_q;
    assign last_word  = (idx_q == IDX_W'(WPL - 1));

    // Sequence bits above the word width never reach the header word.
    assign unused_seq_bits = ^head_seq;

    assign busy = ~q_empty | (state_q != IDLE);

    // Line counter and sticky overflow; a new drop beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            line_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) line_count <= line_count + LINE_COUNT_WIDTH'(1);
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    // Stream FSM state and word index registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and output decode; outputs depend only on registered state,
    // so data/last stay put while the sink stalls.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!q_empty) state_d = HEADER;
            end
            HEADER: begin
                out_valid = 1'b1;
                out_data  = WORD_WIDTH'(head_seq);
                if (out_ready) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                out_valid = 1'b1;
                out_data  = head_words[word_sel];
                out_last  = last_word;
                if (out_ready) begin
                    if (last_word) begin
                        pop     = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_print_line_streamer.sv
// Directed, table-driven bench for print_line_streamer (16-dot head, byte words).
module tb_print_line_streamer;

    localparam int HW = 16;
    localparam int WW = 8;
    localparam int LS = 2;

    logic          clk;
    logic          reset;
    logic          line_advance_tick;
    logic [HW-1:0] print_line;
    logic          capture_enable;
    logic          clear_overflow;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [15:0]   line_count;
    logic          overflow;
    logic          busy;

    print_line_streamer #(.HEAD_WIDTH(HW), .WORD_WIDTH(WW), .LINE_SLOTS(LS)) dut (
        .clk               (clk),
        .reset             (reset),
        .line_advance_tick (line_advance_tick),
        .print_line        (print_line),
        .capture_enable    (capture_enable),
        .clear_overflow    (clear_overflow),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .line_count        (line_count),
        .overflow          (overflow),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per cycle: inputs driven for the coming edge, and the outputs expected
    // in this cycle (before that edge). rst=1 holds reset low for the edge.
    typedef struct {
        bit          rst, tick, cap, clr, rdy;
        logic [15:0] line;
        bit          ev;
        logic [7:0]  ed;
        bit          el, eb;
        logic [15:0] ec;
        bit          eo;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic v(input bit rst, tick, cap, clr, rdy, input logic [15:0] line,
                     input bit ev, input logic [7:0] ed, input bit el, eb,
                     input logic [15:0] ec, input bit eo);
        vec_t r;
        r.rst = rst; r.tick = tick; r.cap = cap; r.clr = clr; r.rdy = rdy;
        r.line = line; r.ev = ev; r.ed = ed; r.el = el; r.eb = eb; r.ec = ec; r.eo = eo;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    endtask

    initial begin
        reset = 1'b0; line_advance_tick = 1'b0; print_line = '0;
        capture_enable = 1'b1; clear_overflow = 1'b0; out_ready = 1'b0;

        // 1: single line, sink always ready
        v(0,1,1,0,1,16'hA55A, 0,8'h00,0,0,16'd0,0);
        v(0,0,1,0,1,16'h0000, 0,8'h00,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'h00,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'hA5,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'h5A,1,1,16'd1,0);
        v(1,0,1,0,1,16'h0000, 0,8'h00,0,0,16'd1,0);
        // 2: fill while stalled, third tick dropped; tick on final handshake also dropped
        v(0,1,1,0,0,16'h1111, 0,8'h00,0,0,16'd0,0);
        v(0,1,1,0,0,16'h2222, 0,8'h00,0,1,16'd1,0);
        v(0,1,1,0,0,16'h3333, 1,8'h00,0,1,16'd2,0);
        v(0,0,1,0,0,16'h0000, 1,8'h00,0,1,16'd2,1);
        v(0,0,1,0,1,16'h0000, 1,8'h00,0,1,16'd2,1);
        v(0,0,1,0,1,16'h0000, 1,8'h11,0,1,16'd2,1);
        v(0,1,1,0,1,16'h4444, 1,8'h11,1,1,16'd2,1);
        v(0,0,1,0,1,16'h0000, 0,8'h00,0,1,16'd2,1);
        v(0,0,1,0,1,16'h0000, 1,8'h01,0,1,16'd2,1);
        v(0,0,1,0,1,16'h0000, 1,8'h22,0,1,16'd2,1);
        v(0,0,1,0,1,16'h0000, 1,8'h22,1,1,16'd2,1);
        v(1,0,1,0,1,16'h0000, 0,8'h00,0,0,16'd2,1);
        // 3: ready 1-0-0-1 mid-line, then a stall on the last word
        v(0,1,1,0,0,16'hBEEF, 0,8'h00,0,0,16'd0,0);
        v(0,0,1,0,0,16'h0000, 0,8'h00,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'h00,0,1,16'd1,0);
        v(0,0,1,0,0,16'h0000, 1,8'hBE,0,1,16'd1,0);
        v(0,0,1,0,0,16'h0000, 1,8'hBE,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'hBE,0,1,16'd1,0);
        v(0,0,1,0,0,16'h0000, 1,8'hEF,1,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'hEF,1,1,16'd1,0);
        v(1,0,1,0,1,16'h0000, 0,8'h00,0,0,16'd1,0);
        // 4: disabled tick ignored; drop+clear keeps overflow; enable falls mid-stream
        v(0,1,0,0,0,16'hFFFF, 0,8'h00,0,0,16'd0,0);
        v(0,0,0,0,0,16'h0000, 0,8'h00,0,0,16'd0,0);
        v(0,1,1,0,0,16'h1234, 0,8'h00,0,0,16'd0,0);
        v(0,1,1,0,0,16'h5678, 0,8'h00,0,1,16'd1,0);
        v(0,1,1,0,0,16'h9ABC, 1,8'h00,0,1,16'd2,0);
        v(0,1,1,1,0,16'hDEF0, 1,8'h00,0,1,16'd2,1);
        v(0,0,1,0,0,16'h0000, 1,8'h00,0,1,16'd2,1);
        v(0,0,1,1,0,16'h0000, 1,8'h00,0,1,16'd2,1);
        v(0,1,0,0,0,16'h1357, 1,8'h00,0,1,16'd2,0);
        v(0,0,0,0,1,16'h0000, 1,8'h00,0,1,16'd2,0);
        v(0,0,0,0,1,16'h0000, 1,8'h12,0,1,16'd2,0);
        v(0,0,0,0,1,16'h0000, 1,8'h34,1,1,16'd2,0);
        v(0,0,0,0,1,16'h0000, 0,8'h00,0,1,16'd2,0);
        v(0,0,0,0,1,16'h0000, 1,8'h01,0,1,16'd2,0);
        v(0,0,0,0,1,16'h0000, 1,8'h56,0,1,16'd2,0);
        v(0,0,0,0,1,16'h0000, 1,8'h78,1,1,16'd2,0);
        v(1,0,0,0,1,16'h0000, 0,8'h00,0,0,16'd2,0);
        // 5: reset pulse in DATA discards the line; next tick streams normally
        v(0,1,1,0,1,16'hCAFE, 0,8'h00,0,0,16'd0,0);
        v(0,0,1,0,1,16'h0000, 0,8'h00,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'h00,0,1,16'd1,0);
        v(1,0,1,0,1,16'h0000, 1,8'hCA,0,1,16'd1,0);
        v(0,1,1,0,1,16'h0F0F, 0,8'h00,0,0,16'd0,0);
        v(0,0,1,0,1,16'h0000, 0,8'h00,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'h00,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'h0F,0,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 1,8'h0F,1,1,16'd1,0);
        v(0,0,1,0,1,16'h0000, 0,8'h00,0,0,16'd1,0);

        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            chk("valid", i, 32'(out_valid), 32'(vecs[i].ev));
            chk("busy",  i, 32'(busy),      32'(vecs[i].eb));
            chk("count", i, 32'(line_count), 32'(vecs[i].ec));
            chk("ovf",   i, 32'(overflow),  32'(vecs[i].eo));
            if (vecs[i].ev) begin
                chk("data", i, 32'(out_data), 32'(vecs[i].ed));
                chk("last", i, 32'(out_last), 32'(vecs[i].el));
            end
            reset             = ~vecs[i].rst;
            line_advance_tick = vecs[i].tick;
            capture_enable    = vecs[i].cap;
            clear_overflow    = vecs[i].clr;
            out_ready         = vecs[i].rdy;
            print_line        = vecs[i].line;
        end

        // 6: counter preloaded to 0xFFFF; next capture carries header FF and wraps count
        @(negedge clk);
        line_advance_tick = 1'b0; out_ready = 1'b1; capture_enable = 1'b1;
        force dut.line_count = 16'hFFFF;
        #1 release dut.line_count;
        chk("t6_preload", 0, 32'(line_count), 32'hFFFF);
        line_advance_tick = 1'b1; print_line = 16'h1234;
        @(negedge clk);
        line_advance_tick = 1'b0;
        chk("t6_wrap", 0, 32'(line_count), 32'h0);
        chk("t6_busy", 0, 32'(busy), 32'h1);
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        chk("t6_hdr_valid", 0, 32'(out_valid), 32'h1);
        chk("t6_hdr", 0, 32'(out_data), 32'hFF);
        @(negedge clk);
        chk("t6_d0", 0, 32'(out_data), 32'h12);
        @(negedge clk);
        chk("t6_d1", 0, 32'(out_data), 32'h34);
        chk("t6_last", 0, 32'(out_last), 32'h1);
        @(negedge clk);
        chk("t6_idle", 0, 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
